mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the 16-bit pipelined core, directly downstream of the execute-stage ALU. Accepts one instruction per handshake from execute (ALU result plus store data and control), performs loads/stores against a variable-latency data memory, and delivers a registered result to writeback. Back-pressures execute while a memory access is outstanding and freezes after a halt or misaligned access.

## Interface
- No parameters; data width fixed at 16 bits, register index 3 bits.
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ex_valid  in  1  execute presents an instruction
- ex_ready  out  1  stage can accept this cycle
- ex_res  in  16  ALU result (memory address for ld/st)
- ex_st_data  in  16  store data (Rt)
- ex_mem_rd / ex_mem_wr  in  1 each  load / store (never both)
- ex_halt  in  1  instruction is HALT
- ex_wr_en  in  1  instruction writes a register
- ex_wr_reg  in  3  destination register
- dmem_req  out  1  memory request, level, held until done
- dmem_wr  out  1  1 = write
- dmem_addr  out  16  word-aligned byte address
- dmem_wdata  out  16  write data
- dmem_rdata  in  16  read data, valid with dmem_done
- dmem_done  in  1  one-cycle completion pulse
- wb_valid  out  1  wb_* valid this cycle (one-cycle pulse per instruction)
- wb_data  out  16  load data or ALU result
- wb_wr_en  out  1  register write enable (already gated by wb_valid)
- wb_wr_reg  out  3  destination register
- wb_halt  out  1  retiring instruction halts the core
- err  out  1  sticky misaligned-access flag

## Operation
- States: IDLE, WAIT, HALTED. Accept = ex_valid & ex_ready; ex_ready = (state == IDLE).
- IDLE, accept, no mem op, no halt: next cycle wb_valid=1, wb_data=ex_res, wb_wr_en=ex_wr_en, wb_wr_reg=ex_wr_reg. Stay IDLE.
- IDLE, accept, mem op, ex_res[0]=0: latch addr, wdata, dmem_wr=ex_mem_wr, wr_reg, wr_en (forced 0 for stores); next cycle dmem_req=1; go WAIT.
- IDLE, accept, mem op, ex_res[0]=1: no request issued; next cycle wb_valid=1, wb_wr_en=0, wb_halt=1, err=1; go HALTED.
- IDLE, accept, ex_halt: next cycle wb_valid=1, wb_halt=1, wb_wr_en=0; go HALTED. ex_halt takes priority over mem flags.
- WAIT: dmem_req, dmem_wr, dmem_addr, dmem_wdata held stable. On dmem_done: next cycle wb_valid=1, wb_data=dmem_rdata (load) or latched address (store), dmem_req=0; go IDLE.
- dmem_done outside WAIT ignored. dmem_rdata sampled only on dmem_done in WAIT.
- HALTED: ex_ready=0, dmem_req=0, no further wb_valid until reset.
- wb_data/wb_wr_reg hold their last value when wb_valid=0; consumers qualify with wb_valid.

## Timing
- Reset (async, immediate): state=IDLE, dmem_req=0, dmem_wr=0, dmem_addr=0, dmem_wdata=0, wb_valid=0, wb_data=0, wb_wr_en=0, wb_wr_reg=0, wb_halt=0, err=0. ex_ready=1 once rst_n deasserts.
- Non-memory latency: 1 cycle accept->wb_valid; back-to-back throughput 1 per cycle.
- Memory latency: dmem_req rises cycle N+1 after accept at N; done at earliest N+1 gives wb_valid at N+2. ex_ready low from N+1 through done cycle; new accept possible on cycle after done.
- Reset during WAIT: dmem_req drops asynchronously; no wb_valid produced for the aborted access.
- err stays 1 until reset.

## Test plan
- Reset with rst_n low mid-clock -> all outputs 0, ex_ready=1 after release; toggle rst_n while in WAIT -> dmem_req falls immediately, no wb_valid.
- Three back-to-back ALU ops (res 0x0011,0x0022,0x0033, reg 1,2,3) -> wb_valid three consecutive cycles with matching data/reg, ex_ready never low.
- Load addr 0x0100, memory done 3 cycles after req with rdata 0xBEEF -> ex_ready low 4 cycles, dmem_req held stable, wb_data=0xBEEF, wb_wr_en=1, one wb_valid pulse.
- Store addr 0x0040 data 0x1234, done same cycle req seen -> dmem_wr=1, dmem_wdata=0x1234, wb_valid at accept+2 with wb_wr_en=0.
- Load addr 0x0101 -> no dmem_req, wb_valid with wb_halt=1, err=1; subsequent ex_valid ignored (ex_ready=0).
- HALT followed by ALU op -> single wb_valid with wb_halt=1, then stage frozen; stray dmem_done in IDLE/HALTED produces nothing.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage: forwards ALU results, runs loads/stores against a
// variable-latency data memory, and freezes after HALT or a misaligned access.
module mem_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [15:0] ex_res,
    input  logic [15:0] ex_st_data,
    input  logic        ex_mem_rd,
    input  logic        ex_mem_wr,
    input  logic        ex_halt,
    input  logic        ex_wr_en,
    input  logic [2:0]  ex_wr_reg,
    output logic        dmem_req,
    output logic        dmem_wr,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_done,
    output logic        wb_valid,
    output logic [15:0] wb_data,
    output logic        wb_wr_en,
    output logic [2:0]  wb_wr_reg,
    output logic        wb_halt,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       accept;
    logic       mem_op;
    logic       misaligned;
    logic       pend_wr_en;
    logic [2:0] pend_reg;

    assign accept     = ex_valid && (state == IDLE);
    assign mem_op     = ex_mem_rd || ex_mem_wr;
    assign misaligned = ex_res[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (ex_halt) begin
                        state_next = HALTED;
                    end else if (mem_op) begin
                        state_next = misaligned ? HALTED : WAIT;
                    end
                end
            end
            WAIT: begin
                if (dmem_done) begin
                    state_next = IDLE;
                end
            end
            HALTED: state_next = HALTED;
            default: state_next = IDLE;
        endcase
    end

    // Request follows state directly so a reset in WAIT drops it immediately.
    always_comb begin
        ex_ready = 1'b0;
        dmem_req = 1'b0;
        case (state)
            IDLE: ex_ready = 1'b1;
            WAIT: dmem_req = 1'b1;
            default: begin
                ex_ready = 1'b0;
                dmem_req = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_wr    <= 1'b0;
            dmem_addr  <= 16'h0000;
            dmem_wdata <= 16'h0000;
            pend_wr_en <= 1'b0;
            pend_reg   <= 3'd0;
            wb_valid   <= 1'b0;
            wb_data    <= 16'h0000;
            wb_wr_en   <= 1'b0;
            wb_wr_reg  <= 3'd0;
            wb_halt    <= 1'b0;
            err        <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            wb_wr_en <= 1'b0;
            wb_halt  <= 1'b0;
            if (accept) begin
                if (ex_halt) begin
                    wb_valid <= 1'b1;
                    wb_halt  <= 1'b1;
                end else if (mem_op && misaligned) begin
                    wb_valid <= 1'b1;
                    wb_halt  <= 1'b1;
                    err      <= 1'b1;
                end else if (mem_op) begin
                    dmem_wr    <= ex_mem_wr;
                    dmem_addr  <= ex_res;
                    dmem_wdata <= ex_st_data;
                    pend_wr_en <= ex_wr_en && !ex_mem_wr;
                    pend_reg   <= ex_wr_reg;
                end else begin
                    wb_valid  <= 1'b1;
                    wb_data   <= ex_res;
                    wb_wr_en  <= ex_wr_en;
                    wb_wr_reg <= ex_wr_reg;
                end
            end else if ((state == WAIT) && dmem_done) begin
                // Stores retire with their address as the result value.
                wb_valid  <= 1'b1;
                wb_data   <= dmem_wr ? dmem_addr : dmem_rdata;
                wb_wr_en  <= pend_wr_en;
                wb_wr_reg <= pend_reg;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table of ALU ops plus hand-written
// load/store/halt/misaligned/reset sequences.
module tb_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [15:0] ex_res;
    logic [15:0] ex_st_data;
    logic        ex_mem_rd;
    logic        ex_mem_wr;
    logic        ex_halt;
    logic        ex_wr_en;
    logic [2:0]  ex_wr_reg;
    logic        dmem_req;
    logic        dmem_wr;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic [15:0] dmem_rdata;
    logic        dmem_done;
    logic        wb_valid;
    logic [15:0] wb_data;
    logic        wb_wr_en;
    logic [2:0]  wb_wr_reg;
    logic        wb_halt;
    logic        err;

    int total;
    int bad;

    typedef struct {
        logic        valid;
        logic [15:0] res;
        logic        wr_en;
        logic [2:0]  wr_reg;
        logic        exp_ready;
        logic        exp_wb_valid;
        logic [15:0] exp_data;
        logic        exp_wr_en;
        logic [2:0]  exp_reg;
    } vec_t;

    vec_t vecs[5];

    mem_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_res     (ex_res),
        .ex_st_data (ex_st_data),
        .ex_mem_rd  (ex_mem_rd),
        .ex_mem_wr  (ex_mem_wr),
        .ex_halt    (ex_halt),
        .ex_wr_en   (ex_wr_en),
        .ex_wr_reg  (ex_wr_reg),
        .dmem_req   (dmem_req),
        .dmem_wr    (dmem_wr),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_done  (dmem_done),
        .wb_valid   (wb_valid),
        .wb_data    (wb_data),
        .wb_wr_en   (wb_wr_en),
        .wb_wr_reg  (wb_wr_reg),
        .wb_halt    (wb_halt),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL timeout actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ex_valid   = 1'b0;
        ex_res     = 16'h0000;
        ex_st_data = 16'h0000;
        ex_mem_rd  = 1'b0;
        ex_mem_wr  = 1'b0;
        ex_halt    = 1'b0;
        ex_wr_en   = 1'b0;
        ex_wr_reg  = 3'd0;
        dmem_rdata = 16'h0000;
        dmem_done  = 1'b0;
    endtask

    task automatic apply_stimulus(input logic valid, input logic [15:0] res, input logic [15:0] st_data,
                                  input logic rd, input logic wr, input logic halt,
                                  input logic wr_en, input logic [2:0] wr_reg);
        ex_valid   = valid;
        ex_res     = res;
        ex_st_data = st_data;
        ex_mem_rd  = rd;
        ex_mem_wr  = wr;
        ex_halt    = halt;
        ex_wr_en   = wr_en;
        ex_wr_reg  = wr_reg;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        #3;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        int low_cycles;
        total = 0;
        bad   = 0;
        clear_inputs();
        rst_n = 1'b1;

        vecs[0] = '{1'b1, 16'h0011, 1'b1, 3'd1, 1'b1, 1'b1, 16'h0011, 1'b1, 3'd1};
        vecs[1] = '{1'b1, 16'h0022, 1'b1, 3'd2, 1'b1, 1'b1, 16'h0022, 1'b1, 3'd2};
        vecs[2] = '{1'b1, 16'h0033, 1'b1, 3'd3, 1'b1, 1'b1, 16'h0033, 1'b1, 3'd3};
        vecs[3] = '{1'b0, 16'h0044, 1'b1, 3'd4, 1'b1, 1'b0, 16'h0033, 1'b0, 3'd3};
        vecs[4] = '{1'b1, 16'h0055, 1'b0, 3'd6, 1'b1, 1'b1, 16'h0055, 1'b0, 3'd6};

        // Reset asserted mid-cycle.
        #13;
        rst_n = 1'b0;
        #1;
        check_output("rst_dmem_req", {15'd0, dmem_req}, 16'h0000);
        check_output("rst_dmem_wr", {15'd0, dmem_wr}, 16'h0000);
        check_output("rst_dmem_addr", dmem_addr, 16'h0000);
        check_output("rst_dmem_wdata", dmem_wdata, 16'h0000);
        check_output("rst_wb_valid", {15'd0, wb_valid}, 16'h0000);
        check_output("rst_wb_data", wb_data, 16'h0000);
        check_output("rst_wb_wr_en", {15'd0, wb_wr_en}, 16'h0000);
        check_output("rst_wb_wr_reg", {13'd0, wb_wr_reg}, 16'h0000);
        check_output("rst_wb_halt", {15'd0, wb_halt}, 16'h0000);
        check_output("rst_err", {15'd0, err}, 16'h0000);
        step();
        rst_n = 1'b1;
        #1;
        check_output("rst_ex_ready", {15'd0, ex_ready}, 16'h0001);

        // Back-to-back ALU ops from the vector table.
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(vecs[i].valid, vecs[i].res, 16'h0000, 1'b0, 1'b0, 1'b0,
                           vecs[i].wr_en, vecs[i].wr_reg);
            check_output($sformatf("alu%0d_ready", i), {15'd0, ex_ready}, {15'd0, vecs[i].exp_ready});
            step();
            check_output($sformatf("alu%0d_wb_valid", i), {15'd0, wb_valid}, {15'd0, vecs[i].exp_wb_valid});
            check_output($sformatf("alu%0d_wb_data", i), wb_data, vecs[i].exp_data);
            check_output($sformatf("alu%0d_wb_wr_en", i), {15'd0, wb_wr_en}, {15'd0, vecs[i].exp_wr_en});
            check_output($sformatf("alu%0d_wb_wr_reg", i), {13'd0, wb_wr_reg}, {13'd0, vecs[i].exp_reg});
        end
        clear_inputs();
        step();

        // Load 0x0100, done three cycles after the request is first seen.
        apply_stimulus(1'b1, 16'h0100, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 3'd5);
        step();
        clear_inputs();
        low_cycles = 0;
        for (int c = 0; c < 4; c++) begin
            if (!ex_ready) low_cycles++;
            check_output($sformatf("ld_req_c%0d", c), {15'd0, dmem_req}, 16'h0001);
            check_output($sformatf("ld_addr_c%0d", c), dmem_addr, 16'h0100);
            check_output($sformatf("ld_wr_c%0d", c), {15'd0, dmem_wr}, 16'h0000);
            check_output($sformatf("ld_wbv_c%0d", c), {15'd0, wb_valid}, 16'h0000);
            if (c == 3) begin
                dmem_done  = 1'b1;
                dmem_rdata = 16'hBEEF;
            end
            step();
        end
        dmem_done  = 1'b0;
        dmem_rdata = 16'h0000;
        check_output("ld_ready_low_cycles", low_cycles[15:0], 16'd4);
        check_output("ld_wb_valid", {15'd0, wb_valid}, 16'h0001);
        check_output("ld_wb_data", wb_data, 16'hBEEF);
        check_output("ld_wb_wr_en", {15'd0, wb_wr_en}, 16'h0001);
        check_output("ld_wb_wr_reg", {13'd0, wb_wr_reg}, 16'h0005);
        check_output("ld_req_dropped", {15'd0, dmem_req}, 16'h0000);
        check_output("ld_ready_back", {15'd0, ex_ready}, 16'h0001);
        step();
        check_output("ld_single_pulse", {15'd0, wb_valid}, 16'h0000);

        // Store 0x0040 <- 0x1234, done in the same cycle the request appears.
        apply_stimulus(1'b1, 16'h0040, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b1, 3'd7);
        step();
        clear_inputs();
        check_output("st_req", {15'd0, dmem_req}, 16'h0001);
        check_output("st_dmem_wr", {15'd0, dmem_wr}, 16'h0001);
        check_output("st_wdata", dmem_wdata, 16'h1234);
        check_output("st_addr", dmem_addr, 16'h0040);
        dmem_done = 1'b1;
        step();
        dmem_done = 1'b0;
        check_output("st_wb_valid", {15'd0, wb_valid}, 16'h0001);
        check_output("st_wb_wr_en", {15'd0, wb_wr_en}, 16'h0000);
        check_output("st_wb_data", wb_data, 16'h0040);

        // Stray done while idle produces nothing.
        dmem_done  = 1'b1;
        dmem_rdata = 16'hDEAD;
        step();
        dmem_done = 1'b0;
        check_output("idle_done_wbv", {15'd0, wb_valid}, 16'h0000);
        check_output("idle_done_ready", {15'd0, ex_ready}, 16'h0001);

        // Reset while waiting aborts the access.
        apply_stimulus(1'b1, 16'h0200, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2);
        step();
        clear_inputs();
        check_output("abort_req_before", {15'd0, dmem_req}, 16'h0001);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("abort_req_async", {15'd0, dmem_req}, 16'h0000);
        #2;
        rst_n = 1'b1;
        step();
        check_output("abort_wbv", {15'd0, wb_valid}, 16'h0000);
        check_output("abort_ready", {15'd0, ex_ready}, 16'h0001);

        // Misaligned load: no request, halt with error, then frozen.
        apply_stimulus(1'b1, 16'h0101, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4);
        step();
        clear_inputs();
        check_output("mis_req", {15'd0, dmem_req}, 16'h0000);
        check_output("mis_wbv", {15'd0, wb_valid}, 16'h0001);
        check_output("mis_halt", {15'd0, wb_halt}, 16'h0001);
        check_output("mis_wr_en", {15'd0, wb_wr_en}, 16'h0000);
        check_output("mis_err", {15'd0, err}, 16'h0001);
        check_output("mis_ready", {15'd0, ex_ready}, 16'h0000);
        apply_stimulus(1'b1, 16'h0077, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1);
        step();
        clear_inputs();
        check_output("mis_after_wbv", {15'd0, wb_valid}, 16'h0000);
        check_output("mis_err_sticky", {15'd0, err}, 16'h0001);
        do_reset();
        check_output("mis_err_cleared", {15'd0, err}, 16'h0000);

        // HALT (with a load flag, halt wins) then an ALU op and a stray done.
        apply_stimulus(1'b1, 16'h0300, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3);
        step();
        check_output("halt_wbv", {15'd0, wb_valid}, 16'h0001);
        check_output("halt_flag", {15'd0, wb_halt}, 16'h0001);
        check_output("halt_wr_en", {15'd0, wb_wr_en}, 16'h0000);
        check_output("halt_no_req", {15'd0, dmem_req}, 16'h0000);
        check_output("halt_err", {15'd0, err}, 16'h0000);
        apply_stimulus(1'b1, 16'h0088, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd6);
        check_output("halt_ready", {15'd0, ex_ready}, 16'h0000);
        step();
        clear_inputs();
        check_output("halt_after_wbv", {15'd0, wb_valid}, 16'h0000);
        dmem_done = 1'b1;
        step();
        dmem_done = 1'b0;
        check_output("halt_done_wbv", {15'd0, wb_valid}, 16'h0000);
        check_output("halt_done_req", {15'd0, dmem_req}, 16'h0000);
        check_output("halt_still_frozen", {15'd0, ex_ready}, 16'h0000);
        do_reset();
        check_output("halt_reset_ready", {15'd0, ex_ready}, 16'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
